// File: rtl/alu_nbit_multiciclo.sv
// N-bit ALU with a valid/ready handshake on both sides. Logic and arithmetic ops
// finish in one cycle; shifts move one bit position per cycle.
module alu_nbit_multiciclo #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       operacion_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] resultado_o,
  output logic             zero_o,
  output logic             carry_o,
  output logic             overflow_o,
  output logic             illegal_o
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLT  = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLTU = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SRL  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;

  state_t             r_state;
  logic [SHAMT_W-1:0] r_count;
  logic [WIDTH-1:0]   r_shreg;
  logic [3:0]         r_op;
  logic [WIDTH-1:0]   r_result;
  logic               r_zero, r_carry, r_overflow, r_illegal;
  logic               r_valid, r_ready;

  logic [WIDTH:0]     w_sum, w_diff;
  logic               w_add_ovf, w_sub_ovf;
  logic [WIDTH-1:0]   w_alu_res;
  logic               w_alu_carry, w_alu_ovf, w_alu_illegal, w_is_shift;
  logic [SHAMT_W-1:0] w_shamt;
  logic [WIDTH-1:0]   w_shift_next;

  // Subtraction is a + ~b + 1, so its carry-out is the "no borrow" indicator.
  assign w_sum     = {1'b0, a_i} + {1'b0, b_i};
  assign w_diff    = {1'b0, a_i} + {1'b0, ~b_i} + {{WIDTH{1'b0}}, 1'b1};
  assign w_add_ovf = ~(a_i[WIDTH-1] ^ b_i[WIDTH-1]) & (w_sum[WIDTH-1] ^ a_i[WIDTH-1]);
  assign w_sub_ovf = (a_i[WIDTH-1] ^ b_i[WIDTH-1]) & (w_diff[WIDTH-1] ^ a_i[WIDTH-1]);
  assign w_shamt   = b_i[SHAMT_W-1:0];

  // NOTE: every signal assigned in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    w_alu_res     = '0;
    w_alu_carry   = 1'b0;
    w_alu_ovf     = 1'b0;
    w_alu_illegal = 1'b0;
    w_is_shift    = 1'b0;
    case (operacion_i)
      OP_AND:  w_alu_res = a_i & b_i;
      OP_OR:   w_alu_res = a_i | b_i;
      OP_XOR:  w_alu_res = a_i ^ b_i;
      OP_ADD: begin
        w_alu_res   = w_sum[WIDTH-1:0];
        w_alu_carry = w_sum[WIDTH];
        w_alu_ovf   = w_add_ovf;
      end
      OP_SUB: begin
        w_alu_res   = w_diff[WIDTH-1:0];
        w_alu_carry = w_diff[WIDTH];
        w_alu_ovf   = w_sub_ovf;
      end
      OP_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, w_diff[WIDTH-1] ^ w_sub_ovf};
      OP_SLTU: w_alu_res = {{(WIDTH-1){1'b0}}, ~w_diff[WIDTH]};
      OP_SRL, OP_SLL, OP_SRA: w_is_shift = 1'b1;
      default: w_alu_illegal = 1'b1;
    endcase
  end

  always_comb begin
    w_shift_next = r_shreg;
    case (r_op)
      OP_SRL:  w_shift_next = {1'b0, r_shreg[WIDTH-1:1]};
      OP_SLL:  w_shift_next = {r_shreg[WIDTH-2:0], 1'b0};
      OP_SRA:  w_shift_next = {r_shreg[WIDTH-1], r_shreg[WIDTH-1:1]};
      default: w_shift_next = r_shreg;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_shreg    <= '0;
      r_op       <= '0;
      r_result   <= '0;
      r_zero     <= 1'b0;
      r_carry    <= 1'b0;
      r_overflow <= 1'b0;
      r_illegal  <= 1'b0;
      r_valid    <= 1'b0;
      r_ready    <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (valid_i) begin
            r_op    <= operacion_i;
            r_ready <= 1'b0;
            if (w_is_shift && w_shamt != '0) begin
              r_shreg <= a_i;
              r_count <= w_shamt;
              r_state <= S_SHIFT;
            end else if (w_is_shift) begin
              r_result   <= a_i;
              r_zero     <= (a_i == '0);
              r_carry    <= 1'b0;
              r_overflow <= 1'b0;
              r_illegal  <= 1'b0;
              r_valid    <= 1'b1;
              r_state    <= S_DONE;
            end else begin
              r_result   <= w_alu_res;
              r_zero     <= (w_alu_res == '0);
              r_carry    <= w_alu_carry;
              r_overflow <= w_alu_ovf;
              r_illegal  <= w_alu_illegal;
              r_valid    <= 1'b1;
              r_state    <= S_DONE;
            end
          end
        end
        S_SHIFT: begin
          r_shreg <= w_shift_next;
          r_count <= r_count - 1'b1;
          if (r_count == SHAMT_W'(1)) begin
            r_result   <= w_shift_next;
            r_zero     <= (w_shift_next == '0);
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
            r_illegal  <= 1'b0;
            r_valid    <= 1'b1;
            r_state    <= S_DONE;
          end
        end
        S_DONE: begin
          if (ready_i) begin
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ready_o     = r_ready;
  assign valid_o     = r_valid;
  assign resultado_o = r_result;
  assign zero_o      = r_zero;
  assign carry_o     = r_carry;
  assign overflow_o  = r_overflow;
  assign illegal_o   = r_illegal;

endmodule

// File: tb/tb_alu_nbit_multiciclo.sv
// Scoreboard bench for alu_nbit_multiciclo (WIDTH = 32): a driver queues expected
// responses from an arithmetic reference model, a monitor checks what the DUT presents.
module tb_alu_nbit_multiciclo;

  typedef struct {
    logic [31:0] res;
    logic        z, c, v, ill;
    int          lat;
    int          acc;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b1;
  logic        valid_i = 1'b0;
  logic        ready_i = 1'b1;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic [3:0]  operacion_i = '0;
  logic        ready_o, valid_o, zero_o, carry_o, overflow_o, illegal_o;
  logic [31:0] resultado_o;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   hold_low = 1'b0;
  bit   rand_bp = 1'b0;
  exp_t sb[$];

  alu_nbit_multiciclo #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .valid_i(valid_i), .ready_o(ready_o),
    .a_i(a_i), .b_i(b_i), .operacion_i(operacion_i), .valid_o(valid_o),
    .ready_i(ready_i), .resultado_o(resultado_o), .zero_o(zero_o),
    .carry_o(carry_o), .overflow_o(overflow_o), .illegal_o(illegal_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the ops expressed as plain arithmetic on 32/64-bit values.
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [63:0] u;
    longint      s;
    int          sh;
    e  = '{res: '0, z: 1'b0, c: 1'b0, v: 1'b0, ill: 1'b0, lat: 0, acc: 0};
    sh = int'(b[4:0]);
    case (op)
      4'd0: e.res = a & b;
      4'd1: e.res = a | b;
      4'd2: begin
        u = {32'd0, a} + {32'd0, b};
        e.res = u[31:0];
        e.c = u[32];
        s = longint'($signed(a)) + longint'($signed(b));
        e.v = (s != longint'($signed(e.res)));
      end
      4'd3: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd4: e.res = a ^ b;
      4'd5: e.res = (a < b) ? 32'd1 : 32'd0;
      4'd6: begin
        e.res = a - b;
        e.c = (a >= b);
        s = longint'($signed(a)) - longint'($signed(b));
        e.v = (s != longint'($signed(e.res)));
      end
      4'd7: begin e.res = a >> sh; e.lat = sh; end
      4'd8: begin e.res = a << sh; e.lat = sh; end
      4'd9: begin e.res = 32'($signed(a) >>> sh); e.lat = sh; end
      default: e.ill = 1'b1;
    endcase
    e.z = (e.res == 32'd0);
    return e;
  endfunction

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   n = 0;
    @(negedge clk_i);
    while (!ready_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    check("issue_ready", 64'(ready_o), 64'd1);
    a_i = a;
    b_i = b;
    operacion_i = op;
    valid_i = 1'b1;
    e = model(op, a, b);
    e.acc = cyc + 1;
    sb.push_back(e);
    @(negedge clk_i);
    valid_i = 1'b0;
    a_i = $urandom;
    b_i = $urandom;
    operacion_i = 4'($urandom);
  endtask

  initial begin
    forever begin
      @(posedge clk_i);
      #2;
      ready_i = hold_low ? 1'b0 : (rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1);
    end
  end

  // Monitor: compares results on the first valid cycle, then enforces hold and handshake rules.
  initial begin
    exp_t        e;
    bit          prev_valid = 1'b0;
    bit          prev_ready = 1'b0;
    logic [35:0] snap = '0;
    forever begin
      @(negedge clk_i);
      if (!rst_n_i) begin
        prev_valid = 1'b0;
      end else begin
        if (valid_o) begin
          if (!prev_valid) begin
            if (sb.size() == 0) begin
              check("unexpected_valid", 64'(valid_o), 64'd0);
            end else begin
              e = sb.pop_front();
              check("result", 64'(resultado_o), 64'(e.res));
              check("flags_zcvi", 64'({zero_o, carry_o, overflow_o, illegal_o}),
                    64'({e.z, e.c, e.v, e.ill}));
              check("latency", 64'(cyc), 64'(e.acc + e.lat));
            end
            snap = {resultado_o, zero_o, carry_o, overflow_o, illegal_o};
          end else begin
            check("hold", 64'({resultado_o, zero_o, carry_o, overflow_o, illegal_o}), 64'(snap));
          end
          check("ready_while_valid", 64'(ready_o), 64'd0);
        end else begin
          if (prev_valid && prev_ready) check("ready_after_xfer", 64'(ready_o), 64'd1);
          if (prev_valid && !prev_ready) check("valid_held", 64'(valid_o), 64'd1);
          if (sb.size() > 0 && cyc >= sb[0].acc) check("ready_busy", 64'(ready_o), 64'd0);
        end
        prev_valid = valid_o;
        prev_ready = ready_i;
      end
    end
  end

  initial begin
    int n;
    #2 rst_n_i = 1'b0;
    #1;
    check("reset_outputs", 64'({valid_o, resultado_o, zero_o, carry_o, overflow_o, illegal_o}), 64'd0);
    check("reset_ready", 64'(ready_o), 64'd1);
    repeat (2) @(posedge clk_i);
    #3 rst_n_i = 1'b1;

    issue(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001);
    issue(4'b0110, 32'd5, 32'd5);
    issue(4'b0011, 32'hFFFF_FFFF, 32'd1);
    issue(4'b0101, 32'hFFFF_FFFF, 32'd1);
    issue(4'b0010, 32'hFFFF_FFFF, 32'd1);
    issue(4'b1001, 32'h8000_0000, 32'd4);
    issue(4'b0111, 32'h8000_0000, 32'd4);
    issue(4'b1000, 32'd1, 32'h0000_0020);
    issue(4'b1000, 32'd1, 32'd31);
    issue(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0);

    // Backpressure with a competing request held on the input side.
    hold_low = 1'b1;
    issue(4'b0100, 32'hA5A5_0F0F, 32'h0F0F_A5A5);
    n = 0;
    while (!valid_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    check("bp_valid", 64'(valid_o), 64'd1);
    repeat (3) begin
      @(negedge clk_i);
      valid_i = 1'b1;
      a_i = $urandom;
      b_i = $urandom;
      operacion_i = 4'($urandom_range(0, 6));
    end
    hold_low = 1'b0;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (valid_o && n < 20);
    valid_i = 1'b0;
    check("bp_release", 64'(valid_o), 64'd0);

    // Asynchronous reset in the middle of a shift.
    issue(4'b1000, 32'd1, 32'd20);
    repeat (4) @(negedge clk_i);
    @(posedge clk_i);
    #3 rst_n_i = 1'b0;
    #1;
    check("midshift_reset_outputs",
          64'({valid_o, resultado_o, zero_o, carry_o, overflow_o, illegal_o}), 64'd0);
    check("midshift_reset_ready", 64'(ready_o), 64'd1);
    sb.delete();
    repeat (2) @(posedge clk_i);
    #3 rst_n_i = 1'b1;
    issue(4'b0010, 32'd2, 32'd3);

    rand_bp = 1'b1;
    repeat (120) begin
      logic [3:0] op;
      op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      issue(op, pick_val(), pick_val());
    end

    n = 0;
    while ((sb.size() > 0 || valid_o) && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    check("drain", 64'(sb.size()), 64'd0);
    repeat (2) @(negedge clk_i);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
